// File: rtl/cmp_sort_ctrl.sv
// Bubble-sort controller that time-shares one 8-bit comparator over a DEPTH-byte block.
// Optional swap statistics port oSwapCnt is enabled by defining SORT_STATS_EN.
module cmp_sort_ctrl #(
   parameter int DEPTH = 4
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic [7:0] iData,
   input  logic       iValid,
   output logic       oReady,
   input  logic       iDescend,
   output logic [7:0] oData,
   output logic       oValid,
   input  logic       iReady,
   output logic       oBusy
`ifdef SORT_STATS_EN
   ,
   output logic [5:0] oSwapCnt
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
   localparam logic [PW-1:0] LAST_CMP = PW'(DEPTH - 2);

   typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   pass_q, pass_d;
   logic [PW-1:0]   j_q, j_d;
   logic            swap_q, swap_d;
   logic            desc_q, desc_d;
   logic            rdy_q;
   logic [7:0]      mem_q [DEPTH];
   logic [7:0]      mem_d [DEPTH];

   logic [7:0]      cmp_a, cmp_b;
   logic            cmp_gt, cmp_eq, cmp_lt;
   logic            do_swap, in_xfer, out_xfer, first_xfer;

   // The single shared comparator: always looks at the adjacent pair selected by j.
   assign cmp_a  = mem_q[j_q];
   assign cmp_b  = mem_q[j_q + 1'b1];
   assign cmp_gt = (cmp_a > cmp_b);
   assign cmp_eq = (cmp_a == cmp_b);
   assign cmp_lt = (cmp_a < cmp_b);

   // Equal pairs never swap, which keeps the sort stable.
   assign do_swap    = (state_q == SORT) && !cmp_eq && (desc_q ? cmp_lt : cmp_gt);
   assign in_xfer    = iValid && oReady;
   assign out_xfer   = oValid && iReady;
   assign first_xfer = in_xfer && (wr_ptr_q == '0);

   always_comb begin
      oReady = (state_q == LOAD) && rdy_q;
      oBusy  = (state_q == SORT);
      oValid = (state_q == DRAIN);
      oData  = oValid ? mem_q[rd_ptr_q] : 8'h00;
   end

   // NOTE: every _d signal takes its _q value first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      pass_d   = pass_q;
      j_d      = j_q;
      swap_d   = swap_q;
      desc_d   = desc_q;
      mem_d    = mem_q;

      case (state_q)
         LOAD: begin
            if (in_xfer) begin
               mem_d[wr_ptr_q] = iData;
               if (first_xfer) desc_d = iDescend;
               if (wr_ptr_q == LAST_IDX) begin
                  wr_ptr_d = '0;
                  j_d      = '0;
                  pass_d   = '0;
                  swap_d   = 1'b0;
                  state_d  = SORT;
               end else begin
                  wr_ptr_d = wr_ptr_q + 1'b1;
               end
            end
         end
         SORT: begin
            if (do_swap) begin
               mem_d[j_q]        = cmp_b;
               mem_d[j_q + 1'b1] = cmp_a;
            end
            if (j_q == LAST_CMP) begin
               // A clean pass means the block is already ordered; stop early.
               if (!(swap_q || do_swap) || (pass_q == LAST_CMP)) begin
                  state_d = DRAIN;
               end else begin
                  pass_d = pass_q + 1'b1;
                  j_d    = '0;
                  swap_d = 1'b0;
               end
            end else begin
               j_d    = j_q + 1'b1;
               swap_d = swap_q || do_swap;
            end
         end
         DRAIN: begin
            if (out_xfer) begin
               if (rd_ptr_q == LAST_IDX) begin
                  rd_ptr_d = '0;
                  state_d  = LOAD;
               end else begin
                  rd_ptr_d = rd_ptr_q + 1'b1;
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q  <= LOAD;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         pass_q   <= '0;
         j_q      <= '0;
         swap_q   <= 1'b0;
         desc_q   <= 1'b0;
         rdy_q    <= 1'b0;
         // NOTE: the block buffer is a handful of flops, not a RAM, so it can and does take the reset.
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         pass_q   <= pass_d;
         j_q      <= j_d;
         swap_q   <= swap_d;
         desc_q   <= desc_d;
         rdy_q    <= 1'b1;
         mem_q    <= mem_d;
      end
   end

`ifdef SORT_STATS_EN
   logic [5:0] swap_cnt_q, swap_cnt_d;

   always_comb begin
      swap_cnt_d = swap_cnt_q;
      if (first_xfer)   swap_cnt_d = 6'd0;
      else if (do_swap) swap_cnt_d = swap_cnt_q + 6'd1;
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) swap_cnt_q <= 6'd0;
      else      swap_cnt_q <= swap_cnt_d;
   end

   assign oSwapCnt = swap_cnt_q;
`endif

endmodule

// File: doc/cmp_sort_ctrl.md
Name: cmp_sort_ctrl

Overview:
Sequencing controller that time-shares one 8-bit magnitude comparator to sort a small block of bytes.
- Accepts DEPTH bytes over a valid/ready input stream.
- Sorts them in place with a bubble-sort schedule, one comparison per clock.
- Streams the sorted block out over a valid/ready output.
- Sits between a byte producer and consumer wherever ordered data (min/max selection, ranking) is needed.

Parameters:
DEPTH, 4, number of bytes per block; legal range 2..8.

Ports:
iClk  input  1  clock; all state updates on rising edge.
iRst  input  1  asynchronous, active-high reset.
iData  input  8  input byte.
iValid  input  1  iData is valid.
oReady  output  1  block accepts iData this cycle.
iDescend  input  1  sort order: 0 = ascending, 1 = descending.
oData  output  8  sorted output byte.
oValid  output  1  oData is valid.
iReady  input  1  consumer accepts oData this cycle.
oBusy  output  1  sort in progress.

Behaviour:
- Reset: the asynchronous assertion of iRst forces the following, regardless of current state:
  - state = LOAD
  - write pointer, read pointer, pass counter, index j and swap flag = 0
  - buffer cleared to 0
  - oData = 0, oValid = 0, oBusy = 0
  - oReady forced 0 while iRst is high; oReady = 1 from the first clock edge after release.
- Comparator: compares buf[j] (a) with buf[j+1] (b) and returns {gt, eq, lt}, one-hot.
- State LOAD:
  - oReady = 1.
  - Transfer = iValid & oReady; each transfer writes buf[wr_ptr] and increments wr_ptr.
  - iDescend is latched on the first transfer of a block and held for that whole block.
  - On the DEPTH-th transfer: next state = SORT, wr_ptr = 0, j = 0, pass = 0.
- State SORT:
  - oReady = 0, oBusy = 1.
  - Each cycle compares buf[j] with buf[j+1].
  - Swap when gt (ascending) or lt (descending). Never swap on eq, so the sort is stable.
  - Any swap sets the pass swap flag.
  - j counts 0..DEPTH-2. At j = DEPTH-2:
    - If the pass had no swap, or pass = DEPTH-2 (i.e. DEPTH-1 passes done): next state = DRAIN.
    - Otherwise: pass increments, j = 0, swap flag cleared.
  - Latency is data dependent:
    - Minimum DEPTH-1 cycles (input already ordered).
    - Maximum (DEPTH-1)^2 cycles.
- State DRAIN:
  - oValid = 1, oData = buf[rd_ptr], oBusy = 0, oReady = 0.
  - Transfer = oValid & iReady; increments rd_ptr.
  - While iReady = 0, oData and oValid are held stable.
  - On the DEPTH-th transfer: next state = LOAD, rd_ptr = 0.
- Outside DRAIN: oValid = 0 and oData = 0.
- iValid outside LOAD is ignored; no data is written.
- iReady outside DRAIN is ignored.
- Reset mid-LOAD, mid-SORT or mid-DRAIN: the partial block is discarded and the next block starts from an empty buffer.
- oData, oValid and oBusy are decoded only from registered state and buffer contents; there is no combinational path from inputs to outputs.

Optional Feature:
SORT_STATS_EN
- Defined:
  - Adds output port oSwapCnt [5:0]: the number of swaps performed for the current block.
  - Cleared on reset and on the first LOAD transfer of each block.
  - Increments on every swap in SORT.
  - Holds its value through DRAIN and until the next block starts.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
All scenarios use DEPTH = 4.
1. Ascending, unordered input:
   - Stimulus: iDescend = 0; load 8'h40, 8'h01, 8'h20, 8'h02.
   - Required: oBusy high exactly 9 cycles; drain order 8'h01, 8'h02, 8'h20, 8'h40; oSwapCnt = 4.
2. Ascending, already ordered input:
   - Stimulus: iDescend = 0; load 8'h01, 8'h02, 8'h03, 8'h04.
   - Required: oBusy high 3 cycles (early exit); output order unchanged; oSwapCnt = 0.
3. Descending with equal values:
   - Stimulus: iDescend = 1; load 8'h60, 8'h60, 8'h01, 8'h20.
   - Required: oBusy high 6 cycles; output 8'h60, 8'h60, 8'h20, 8'h01; oSwapCnt = 1.
4. Output backpressure:
   - Stimulus: hold iReady low for 3 cycles after the first oValid.
   - Required: oData stays at the first byte with oValid = 1 throughout; all 4 bytes delivered once iReady rises, with no loss or duplication.
5. Reset mid-SORT:
   - Stimulus: pulse iRst during the 2nd SORT cycle of scenario 1, then load 8'h03, 8'h02, 8'h01, 8'h00.
   - Required: oBusy and oValid drop immediately; oReady = 1 on the edge after release; output 8'h00, 8'h01, 8'h02, 8'h03.
6. Inputs outside their states:
   - Stimulus: hold iValid high with iData = 8'hFF throughout SORT and DRAIN.
   - Required: oReady = 0 during SORT and DRAIN; 8'hFF never appears in the drained block; the next block's loading starts correctly.
